// File: rtl/usb_rx_decoder.sv
// USB receive line decoder: samples D+/D- on each shift_enable strobe, undoes NRZI, finds SYNC, drops stuffed bits, detects EOP and line errors.
// Latency: every output is registered, so results appear one clock after the strobe. Pulses last one cycle.
// Backpressure: none. The decoder follows the line rate, and the downstream logic must consume each bit_valid pulse.
//
// Ports:
//   clk, n_rst                 rising-edge clock, asynchronous active-low reset
//   d_plus_sync, d_minus_sync  synchronized differential line
//   shift_enable               one-cycle strobe at the bit centre (the sample point)
//   d_orig                     last decoded payload bit (held between payload bits)
//   bit_valid                  pulse: d_orig was just loaded with a payload bit
//   sync_found, eop, rx_error  event pulses
//   receiving                  high while in SYNC, DATA or EOP_WAIT
module usb_rx_decoder #(
    parameter int STUFF_LEN  = 6,
    parameter int SYNC_ZEROS = 7
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    input  logic shift_enable,
    output logic d_orig,
    output logic bit_valid,
    output logic sync_found,
    output logic eop,
    output logic rx_error,
    output logic receiving
);

    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int ZW = $clog2(SYNC_ZEROS + 1);
    localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
    localparam logic [ZW-1:0] ZERO_MAX  = ZW'(SYNC_ZEROS);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_WAIT,
        ERROR
    } state_t;

    state_t        state;
    logic          prev_line;
    logic [OW-1:0] ones_cnt;
    logic [ZW-1:0] zero_cnt;
    logic [1:0]    se0_cnt;
    logic          j_seen;      // ERROR: previous sample was J

    logic is_j, is_k, is_se0, is_jk, dec_bit;

    assign is_j    = d_plus_sync & ~d_minus_sync;
    assign is_k    = ~d_plus_sync & d_minus_sync;
    assign is_se0  = ~d_plus_sync & ~d_minus_sync;
    assign is_jk   = is_j | is_k;
    // NRZI: no transition decodes as 1, a transition decodes as 0.
    assign dec_bit = (d_plus_sync == prev_line);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            prev_line  <= 1'b1;
            ones_cnt   <= '0;
            zero_cnt   <= '0;
            se0_cnt    <= '0;
            j_seen     <= 1'b0;
            d_orig     <= 1'b1;
            bit_valid  <= 1'b0;
            sync_found <= 1'b0;
            eop        <= 1'b0;
            rx_error   <= 1'b0;
            receiving  <= 1'b0;
        end else begin
            bit_valid  <= 1'b0;
            sync_found <= 1'b0;
            eop        <= 1'b0;
            rx_error   <= 1'b0;

            if (shift_enable) begin
                // SE0/SE1 carry no NRZI level, so prev_line only follows J/K.
                if (is_jk)
                    prev_line <= d_plus_sync;

                case (state)
                    IDLE: begin
                        if (is_k) begin
                            state     <= SYNC;
                            zero_cnt  <= ZW'(1);
                            receiving <= 1'b1;
                        end
                    end

                    SYNC: begin
                        if (is_jk && !dec_bit && zero_cnt != ZERO_MAX) begin
                            zero_cnt <= zero_cnt + 1'b1;
                        end else if (is_jk && dec_bit && zero_cnt == ZERO_MAX) begin
                            state      <= DATA;
                            sync_found <= 1'b1;
                            ones_cnt   <= OW'(1);   // the closing SYNC 1 counts toward stuffing
                        end else begin
                            state     <= ERROR;
                            rx_error  <= 1'b1;
                            receiving <= 1'b0;
                            j_seen    <= 1'b0;
                        end
                    end

                    DATA: begin
                        if (is_jk) begin
                            if (ones_cnt != STUFF_MAX) begin
                                d_orig    <= dec_bit;
                                bit_valid <= 1'b1;
                                ones_cnt  <= dec_bit ? ones_cnt + 1'b1 : '0;
                            end else if (!dec_bit) begin
                                ones_cnt <= '0;     // stuffed zero: dropped, d_orig held
                            end else begin
                                state     <= ERROR;
                                rx_error  <= 1'b1;
                                receiving <= 1'b0;
                                j_seen    <= 1'b0;
                            end
                        end else if (is_se0) begin
                            state   <= EOP_WAIT;
                            se0_cnt <= 2'd1;
                        end else begin
                            state     <= ERROR;
                            rx_error  <= 1'b1;
                            receiving <= 1'b0;
                            j_seen    <= 1'b0;
                        end
                    end

                    EOP_WAIT: begin
                        if (is_se0 && se0_cnt != 2'd2) begin
                            se0_cnt <= se0_cnt + 1'b1;
                        end else if (is_j) begin
                            state     <= IDLE;
                            eop       <= 1'b1;
                            receiving <= 1'b0;
                        end else begin
                            state     <= ERROR;
                            rx_error  <= 1'b1;
                            receiving <= 1'b0;
                            j_seen    <= 1'b0;
                        end
                    end

                    ERROR: begin
                        if (is_j && j_seen) begin
                            state  <= IDLE;
                            j_seen <= 1'b0;
                        end else begin
                            j_seen <= is_j;
                        end
                    end

                    default: begin
                        state     <= IDLE;
                        receiving <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
